// File: rtl/rom_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | rom_arb_pkg: shared tag type and index-width helper for rom_dp_arbiter     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rom_arb_pkg;

  // Wide enough for the largest legal requester count (16).
  localparam int TAG_IW = 4;

  typedef struct packed {
    logic              valid;
    logic [TAG_IW-1:0] idx;
  } tag_t;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// +----------------------------------------------------------------------------+
// | rr_pick2: combinational two-winner wrapping search starting at ptr         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick2 #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] mask_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            a_valid_o,
  output logic [IW-1:0]   a_idx_o,
  output logic            b_valid_o,
  output logic [IW-1:0]   b_idx_o
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;

  always_comb begin
    a_valid_o = 1'b0;
    a_idx_o   = '0;
    b_valid_o = 1'b0;
    b_idx_o   = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, ptr_i} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(NREQ)) w_sum = w_sum - (IW+1)'(NREQ);
      w_idx = w_sum[IW-1:0];
      if (mask_i[w_idx]) begin
        if (!a_valid_o) begin
          a_valid_o = 1'b1;
          a_idx_o   = w_idx;
        end else if (!b_valid_o) begin
          b_valid_o = 1'b1;
          b_idx_o   = w_idx;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rom_dp_arbiter.sv
// +----------------------------------------------------------------------------+
// | rom_dp_arbiter: grants up to two requesters per cycle onto an external     |
// | dual-port synchronous ROM; ROM_ARB_FIXED_PRIO0_EN gives req0 fixed prio.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rom_dp_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          resp_valid,
  output logic [NREQ*DWIDTH-1:0]   resp_data,
  output logic                     rom_en0,
  output logic                     rom_en1,
  output logic [AWIDTH-1:0]        rom_addr0,
  output logic [AWIDTH-1:0]        rom_addr1,
  input  logic [DWIDTH-1:0]        rom_q0,
  input  logic [DWIDTH-1:0]        rom_q1
);

  localparam int IW = clog2(NREQ);

  logic [IW-1:0]   ptr_q, ptr_d;
  tag_t            tag0_q, tag0_d, tag1_q, tag1_d;
  logic [NREQ-1:0] w_mask;
  logic            w_pa_valid, w_pb_valid, w_a_valid, w_b_valid;
  logic [IW-1:0]   w_pa_idx, w_pb_idx, w_a_idx, w_b_idx;
  logic            w_gnt_a, w_gnt_b;

`ifdef ROM_ARB_FIXED_PRIO0_EN
  // Requester 0 bypasses the rotation; the pointer only rotates over 1..NREQ-1.
  assign w_mask = {req_valid[NREQ-1:1], 1'b0};
`else
  assign w_mask = req_valid;
`endif

  rr_pick2 #(.NREQ(NREQ), .IW(IW)) u_pick (
    .mask_i    (w_mask),
    .ptr_i     (ptr_q),
    .a_valid_o (w_pa_valid),
    .a_idx_o   (w_pa_idx),
    .b_valid_o (w_pb_valid),
    .b_idx_o   (w_pb_idx)
  );

  always_comb begin
    w_a_valid = w_pa_valid;
    w_a_idx   = w_pa_idx;
    w_b_valid = w_pb_valid;
    w_b_idx   = w_pb_idx;
`ifdef ROM_ARB_FIXED_PRIO0_EN
    if (req_valid[0]) begin
      w_a_valid = 1'b1;
      w_a_idx   = '0;
      w_b_valid = w_pa_valid;
      w_b_idx   = w_pa_idx;
    end
`endif
  end

  assign w_gnt_a = w_a_valid & ~stall & ~rst;
  assign w_gnt_b = w_b_valid & ~stall & ~rst;

  always_comb begin
    req_ready = '0;
    if (w_gnt_a) req_ready[w_a_idx] = 1'b1;
    if (w_gnt_b) req_ready[w_b_idx] = 1'b1;
  end

  assign rom_en0   = w_gnt_a;
  assign rom_en1   = w_gnt_b;
  assign rom_addr0 = w_gnt_a ? req_addr[int'(w_a_idx)*AWIDTH +: AWIDTH] : '0;
  assign rom_addr1 = w_gnt_b ? req_addr[int'(w_b_idx)*AWIDTH +: AWIDTH] : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (w_gnt_b)
      ptr_d = (w_b_idx == IW'(NREQ-1)) ? '0 : w_b_idx + IW'(1);
    else if (w_gnt_a)
      ptr_d = (w_a_idx == IW'(NREQ-1)) ? '0 : w_a_idx + IW'(1);
    tag0_d       = '0;
    tag0_d.valid = w_gnt_a;
    tag0_d.idx   = TAG_IW'(w_a_idx);
    tag1_d       = '0;
    tag1_d.valid = w_gnt_b;
    tag1_d.idx   = TAG_IW'(w_b_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      tag0_q <= '0;
      tag1_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      tag0_q <= tag0_d;
      tag1_q <= tag1_d;
    end
  end

  // ROM data lands one cycle after the enable, aligned with the tags.
  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (tag0_q.valid && !rst) begin
      resp_valid[tag0_q.idx[IW-1:0]]                          = 1'b1;
      resp_data[int'(tag0_q.idx[IW-1:0])*DWIDTH +: DWIDTH]   = rom_q0;
    end
    if (tag1_q.valid && !rst) begin
      resp_valid[tag1_q.idx[IW-1:0]]                          = 1'b1;
      resp_data[int'(tag1_q.idx[IW-1:0])*DWIDTH +: DWIDTH]   = rom_q1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_dp_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_rom_dp_arbiter: directed bench pairing the arbiter with a ROM model     |
// | (ROM[a] = a ^ 8'hA5); ROM_ARB_FIXED_PRIO0_EN selects the fixed-prio suite. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rom_dp_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ*DW-1:0] resp_data;
  logic              rom_en0, rom_en1;
  logic [AW-1:0]     rom_addr0, rom_addr1;
  logic [DW-1:0]     rom_q0 = '0;
  logic [DW-1:0]     rom_q1 = '0;

  int n_checks = 0;
  int n_errors = 0;

  rom_dp_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .rom_en0    (rom_en0),
    .rom_en1    (rom_en1),
    .rom_addr0  (rom_addr0),
    .rom_addr1  (rom_addr1),
    .rom_q0     (rom_q0),
    .rom_q1     (rom_q1)
  );

  always #5 clk = ~clk;

  // Dual-port synchronous ROM model.
  always @(posedge clk) begin
    if (rom_en0) rom_q0 <= rom_addr0 ^ 8'hA5;
    if (rom_en1) rom_q1 <= rom_addr1 ^ 8'hA5;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

`ifdef ROM_ARB_FIXED_PRIO0_EN
  initial begin
    logic [3:0] exp_b [6];
    exp_b = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
    req_addr = {8'd40, 8'd30, 8'd20, 8'd10};
    tick(); tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      settle();
      check($sformatf("fixed_ready_c%0d", c), 32'(req_ready), 32'(4'b0001 | (4'b0001 << exp_b[c])));
      check($sformatf("fixed_addr0_c%0d", c), 32'(rom_addr0), 32'd10);
      tick();
    end
    req_valid = '0;
    settle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
`else
  initial begin
    int cnt [NREQ];
    int wait_c [NREQ];
    int max_wait;

    // Reset state
    req_addr = {8'd40, 8'd30, 8'd20, 8'd10};
    req_valid = 4'b1111;
    settle();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_en", 32'({rom_en0, rom_en1}), 32'h0);
    check("rst_addr", 32'({rom_addr0, rom_addr1}), 32'h0);
    tick(); tick();
    rst = 1'b0;
    req_valid = '0;
    settle();
    check("post_rst_resp_valid", 32'(resp_valid), 32'h0);
    check("post_rst_resp_data", resp_data, 32'h0);
    tick();

    // All valid from reset: 0,1 then 2,3
    req_valid = 4'b1111;
    settle();
    check("c0_ready", 32'(req_ready), 32'b0011);
    check("c0_rom0", 32'({rom_en0, rom_addr0}), {23'd0, 1'b1, 8'd10});
    check("c0_rom1", 32'({rom_en1, rom_addr1}), {23'd0, 1'b1, 8'd20});
    tick();
    settle();
    check("c1_ready", 32'(req_ready), 32'b1100);
    check("c1_addrs", 32'({rom_addr0, rom_addr1}), {16'd0, 8'd30, 8'd40});
    check("c1_resp_valid", 32'(resp_valid), 32'b0011);
    check("c1_resp_data", resp_data, 32'h0000B1AF);
    tick();
    req_valid = '0;
    settle();
    check("c2_ready", 32'(req_ready), 32'h0);
    check("c2_resp_valid", 32'(resp_valid), 32'b1100);
    check("c2_resp_data", resp_data, 32'h8DBB0000);
    tick();

    // Single requester 2 for three cycles
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("solo_ready_c%0d", c), 32'(req_ready), 32'b0100);
      check($sformatf("solo_rom0_c%0d", c), 32'({rom_en0, rom_addr0}), {23'd0, 1'b1, 8'd30});
      check($sformatf("solo_rom1_c%0d", c), 32'({rom_en1, rom_addr1}), 32'h0);
      check($sformatf("solo_resp_c%0d", c), 32'(resp_valid), (c == 0) ? 32'h0 : 32'b0100);
      tick();
    end
    req_valid = '0;
    settle();
    check("solo_last_resp", 32'(resp_valid), 32'b0100);
    check("solo_last_data", resp_data, 32'h00BB0000);
    tick();

    // Pointer left at 3: winners 3 then 0
    req_valid = 4'b1111;
    settle();
    check("ptr3_ready", 32'(req_ready), 32'b1001);
    check("ptr3_addrs", 32'({rom_addr0, rom_addr1}), {16'd0, 8'd40, 8'd10});
    tick();

    // Grant 1,0 then stall: no grants, responses still delivered
    req_valid = 4'b0011;
    settle();
    check("pre_stall_ready", 32'(req_ready), 32'b0011);
    tick();
    stall = 1'b1;
    settle();
    check("stall_ready", 32'(req_ready), 32'h0);
    check("stall_en", 32'({rom_en0, rom_en1}), 32'h0);
    check("stall_resp_valid", 32'(resp_valid), 32'b0011);
    check("stall_resp_data", resp_data, 32'h0000B1AF);
    tick();
    stall = 1'b0;
    req_valid = '0;
    settle();
    check("post_stall_resp", 32'(resp_valid), 32'h0);
    tick();

    // Reset with tags in flight
    req_valid = 4'b1111;
    settle();
    check("pre_rst_ready", 32'(req_ready), 32'b0110);
    tick();
    rst = 1'b1;
    settle();
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    settle();
    check("after_rst_resp", 32'(resp_valid), 32'h0);
    tick();
    req_valid = 4'b1010;
    settle();
    check("after_rst_ready", 32'(req_ready), 32'b1010);
    check("after_rst_addr0", 32'(rom_addr0), 32'd20);
    tick();

    // Fairness over 100 cycles, pointer at 0
    for (int i = 0; i < NREQ; i++) begin cnt[i] = 0; wait_c[i] = 0; end
    max_wait = 0;
    req_valid = 4'b1111;
    for (int c = 0; c < 100; c++) begin
      settle();
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          cnt[i]++;
          wait_c[i] = 0;
        end else begin
          wait_c[i]++;
          if (wait_c[i] > max_wait) max_wait = wait_c[i];
        end
      end
      tick();
    end
    for (int i = 0; i < NREQ; i++) check($sformatf("fair_cnt%0d", i), 32'(cnt[i]), 32'd50);
    check("fair_max_wait", 32'(max_wait), 32'd1);

    // Same address on both ports
    req_addr = {8'd40, 8'd30, 8'h37, 8'h37};
    req_valid = 4'b0011;
    settle();
    check("same_addr", 32'({rom_addr0, rom_addr1}), 32'h3737);
    tick();
    req_valid = '0;
    settle();
    check("same_resp_valid", 32'(resp_valid), 32'b0011);
    check("same_resp_data", resp_data, 32'h00009292);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
`endif

endmodule

`default_nettype wire

// File: doc/rom_dp_arbiter.md
ROM_DP_ARBITER -- requirements
Module: rom_dp_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (legal range 2..16).
REQ-002 The block SHALL have parameter AWIDTH, default 8, meaning the ROM address width.
REQ-003 The block SHALL have parameter DWIDTH, default 8, meaning the ROM data width.
REQ-004 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  is the reset, synchronous and active-high.
REQ-006 Port stall  input  1  SHALL block all new grants while high.
REQ-007 Port req_valid  input  NREQ  carries the per-requester read request.
REQ-008 Port req_addr  input  NREQ*AWIDTH  carries the addresses; slice i is [i*AWIDTH +: AWIDTH].
REQ-009 Port req_ready  output  NREQ  is the per-requester grant; the transfer occurs when valid&ready.
REQ-010 Port resp_valid  output  NREQ  is a one-cycle response pulse.
REQ-011 Port resp_data  output  NREQ*DWIDTH  carries the response data; slice i is valid when resp_valid[i]=1.
REQ-012 Ports rom_en0, rom_en1  output  1, and rom_addr0, rom_addr1  output  AWIDTH, SHALL drive the external dual-port synchronous ROM.
REQ-013 Ports rom_q0, rom_q1  input  DWIDTH  carry the ROM read data, valid one cycle after the enable.

Function
REQ-014 Each cycle the block SHALL grant at most two requesters: winner A on port 0 and winner B on port 1.
REQ-015 Winner A SHALL be the first requester with req_valid set, searching upward from pointer ptr with wrap at NREQ.
REQ-016 Winner B SHALL be the next requester with req_valid set after A, continuing the same wrapping search and stopping before ptr.
REQ-017 req_ready SHALL be combinational: it is 1 exactly at A and B, and 0 everywhere when stall=1 or rst=1.
REQ-018 Requesters SHALL NOT make req_valid depend on req_ready; req_ready MAY depend on req_valid.
REQ-019 rom_en0 SHALL equal (A exists); rom_addr0 SHALL equal req_addr slice A; port 1 SHALL behave the same way for B.
REQ-020 Unused ports SHALL drive en=0 and addr=0.
REQ-021 On each grant, registered tags (tag0/tag1: valid bit plus index) SHALL capture A/B.
REQ-022 One cycle after a grant, resp_valid[tag0.idx]=1 with resp_data slice = rom_q0, and likewise for tag1 with rom_q1; total latency SHALL be exactly 1 cycle.
REQ-023 Responses have no backpressure; requesters SHALL always accept them.
REQ-024 resp_data slices without resp_valid SHALL be 0.
REQ-025 Pointer update: if B is granted, ptr SHALL become B+1 mod NREQ; if only A is granted, ptr SHALL become A+1 mod NREQ; with no grant, ptr SHALL hold.
REQ-026 A single valid requester SHALL get port 0 only; port 1 SHALL stay idle.
REQ-027 stall SHALL NOT suppress responses to grants from the previous cycle.
REQ-028 The same address on A and B SHALL be legal; both ports SHALL read independently.

Reset
REQ-029 When rst=1: ptr=0, tag valid bits=0, and on the next cycle resp_valid=0, resp_data=0, rom_en0/1=0, rom_addr0/1=0.
REQ-030 Reset mid-operation: grants issued in the reset cycle SHALL NOT exist, and in-flight responses SHALL be dropped (no resp_valid in the cycle after rst).

Configuration
REQ-031 Macro ROM_ARB_FIXED_PRIO0_EN SHALL select the arbitration mode.
REQ-032 With ROM_ARB_FIXED_PRIO0_EN defined: requester 0, when valid, SHALL always be A; B SHALL be round-robin among 1..NREQ-1 with its own pointer.
REQ-033 With ROM_ARB_FIXED_PRIO0_EN undefined: pure two-winner round-robin per REQ-015..REQ-016 and REQ-025.

Structure
REQ-034 A shared package rom_arb_pkg SHALL hold the tag struct typedef (valid, index) and an index-width constant function clog2(NREQ).
REQ-035 One sub-module, rr_pick2, SHALL implement the combinational two-winner wrapping search (inputs: mask, ptr; outputs: A/B valid+index).
REQ-036 The ROM SHALL be external; the top-level test harness SHALL pair this block with the team's dual-port synchronous ROM.

Verification
REQ-037 NREQ=4, ROM[a]=a^8'hA5, all valid, addrs 10/20/30/40 from reset -> cycle0 grants 0,1; cycle1 grants 2,3; responses of 8'hAF/8'hB1 to req0/req1 one cycle after grant.
REQ-038 Only req2 valid for 3 cycles -> port0 each cycle, rom_en1=0, ptr=3 after the first grant, three resp pulses on req2.
REQ-039 stall=1 in the cycle after a grant of 0,1 -> req_ready=0 and rom_en=0, yet resp_valid[0] and resp_valid[1] still pulse.
REQ-040 rst asserted while tags are valid -> no resp_valid the next cycle; ptr=0; the first post-reset grant goes to the lowest valid index.
REQ-041 Fairness: all 4 valid for 100 cycles -> each requester granted exactly 50 times, and no requester waits more than 2 cycles.
REQ-042 With ROM_ARB_FIXED_PRIO0_EN, all valid for 6 cycles -> req0 is granted every cycle; B rotates 1,2,3,1,2,3.
